// File: rtl/jump_decode_pkg.sv
// rtl/jump_decode_pkg.sv - shared types and constants for the jump/branch decode pipe
// Purpose : control-transfer kind enum, opcode constants, skid-buffer state enum,
//           the decoded-entry struct carried through the pipe, and a target
//           alignment helper.
// Ports   : none (package)
package jump_decode_pkg;

   // Width of the address-carrying fields inside jdec_t.  The pipe's XLEN
   // parameter must be set to this value.
   localparam int JD_XLEN = 32;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // Branch funct3 codes with no defined condition.
   localparam logic [2:0] F3_RSVD_A = 3'b010;
   localparam logic [2:0] F3_RSVD_B = 3'b011;

   typedef enum logic [1:0] {
      JMP_NOP = 2'd0,
      JAL     = 2'd1,
      JALR    = 2'd2,
      BRANCH  = 2'd3
   } jump_ctrl_e;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_e;

   typedef struct packed {
      jump_ctrl_e           ctrl;
      logic [2:0]           funct3;
      logic [4:0]           rd;
      logic [4:0]           rs1;
      logic [4:0]           rs2;
      logic [JD_XLEN-1:0]   imm;
      logic [JD_XLEN-1:0]   target;
      logic [JD_XLEN-1:0]   link;
      logic                 illegal;
      logic                 misalign;
   } jdec_t;

   // 16-bit alignment only needs bit 0 clear; 32-bit needs bits [1:0] clear.
   function automatic logic is_misaligned(input logic [1:0] lsb, input int ialign);
      if (ialign == 16) begin
         return lsb[0];
      end
      return (lsb != 2'b00);
   endfunction

endpackage

// File: rtl/jump_branch_decode_pipe_if.sv
// rtl/jump_branch_decode_pipe_if.sv - upstream/downstream bus of the jump/branch decode pipe
// Purpose : bundles flush, the {instr, pc} input handshake and the decoded
//           output handshake.
// Ports   : slave  = the decode pipe's view (inputs in_*/flush/out_ready,
//                    outputs in_ready/out_*)
//           master = the environment's view (directions reversed)
interface jump_branch_decode_pipe_if
   import jump_decode_pkg::*;
#(
   parameter int XLEN = 32
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [XLEN-1:0]   in_pc;
   logic              out_valid;
   logic              out_ready;
   jump_ctrl_e        out_ctrl;
   logic [2:0]        out_funct3;
   logic [4:0]        out_rd;
   logic [4:0]        out_rs1;
   logic [4:0]        out_rs2;
   logic [XLEN-1:0]   out_imm;
   logic [XLEN-1:0]   out_target;
   logic [XLEN-1:0]   out_link;
   logic              out_illegal;
   logic              out_misalign;

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_ctrl, out_funct3, out_rd, out_rs1, out_rs2,
             out_imm, out_target, out_link, out_illegal, out_misalign
   );

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_ctrl, out_funct3, out_rd, out_rs1, out_rs2,
             out_imm, out_target, out_link, out_illegal, out_misalign
   );

endinterface

// File: rtl/pipe_skid_buffer.sv
// rtl/pipe_skid_buffer.sv - 2-entry registered skid buffer with flush
// Purpose : holds up to two entries between a valid/ready producer and
//           consumer at full throughput; in_ready is a flop so the upstream
//           path never sees a combinational dependency on out_ready.
// Ports   : clk, rst_n (async active-low), flush (drop everything held),
//           in_valid/in_ready/in_data (producer side),
//           out_valid/out_ready/out_data (consumer side, out_data = main entry)
module pipe_skid_buffer
   import jump_decode_pkg::*;
#(
   parameter type T = logic [7:0]
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_data,
   output logic out_valid,
   input  logic out_ready,
   output T     out_data
);

   buf_state_e state_q, state_d;
   logic       in_ready_q;
   T           main_q, skid_q;
   logic       acc, pop;
   logic       load_main, load_skid, main_from_skid;

   assign acc       = in_valid && in_ready_q && !flush;
   assign pop       = out_valid && out_ready;
   assign out_valid = (state_q != BUF_EMPTY);
   assign out_data  = main_q;
   assign in_ready  = in_ready_q;

   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         BUF_EMPTY: begin
            if (acc) begin
               state_d   = BUF_ONE;
               load_main = 1'b1;
            end
         end
         BUF_ONE: begin
            if (acc && pop) begin
               load_main = 1'b1;
            end else if (acc) begin
               state_d   = BUF_FULL;
               load_skid = 1'b1;
            end else if (pop) begin
               state_d   = BUF_EMPTY;
            end
         end
         BUF_FULL: begin
            // in_ready is low here, so only a pop can move the buffer.
            if (pop) begin
               state_d        = BUF_ONE;
               main_from_skid = 1'b1;
            end
         end
         default: state_d = BUF_EMPTY;
      endcase
      // A pop in the flush cycle still completes; everything left is dropped.
      if (flush) begin
         state_d = BUF_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BUF_EMPTY;
         in_ready_q <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != BUF_FULL);
         if (load_main) begin
            main_q <= in_data;
         end else if (main_from_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/jump_branch_decode_pipe.sv
// rtl/jump_branch_decode_pipe.sv - pipelined JAL/JALR/branch decoder
// Purpose : decodes {instr, pc} into control kind, register fields,
//           sign-extended immediate, pc-relative target and link address,
//           flags illegal encodings and misaligned targets, and hands the
//           result downstream through a 2-entry skid buffer (1-cycle latency).
// Params  : XLEN (must equal JD_XLEN), IALIGN (32 or 16), EN_BRANCH
// Ports   : clk, rst_n (async active-low),
//           bus (slave): flush, in_valid/in_ready/in_instr/in_pc,
//           out_valid/out_ready and the decoded out_* fields
module jump_branch_decode_pipe
   import jump_decode_pkg::*;
#(
   parameter int XLEN      = JD_XLEN,
   parameter int IALIGN    = 32,
   parameter bit EN_BRANCH = 1'b1
) (
   input logic                     clk,
   input logic                     rst_n,
   jump_branch_decode_pipe_if.slave bus
);

   localparam logic [XLEN-1:0] LINK_OFS = XLEN'(4);

   logic [31:0]     instr;
   logic [XLEN-1:0] pc;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [XLEN-1:0] imm_i, imm_b, imm_j;
   logic [XLEN-1:0] target_j, target_b, link;
   jdec_t           dec, head;

   assign instr  = bus.in_instr;
   assign pc     = bus.in_pc;
   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];

   assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // All adders wrap modulo 2^XLEN.
   assign target_j = pc + imm_j;
   assign target_b = pc + imm_b;
   assign link     = pc + LINK_OFS;

   always_comb begin
      dec      = '0;
      dec.link = link;
      case (opcode)
         OP_JAL: begin
            dec.ctrl     = JAL;
            dec.rd       = instr[11:7];
            dec.imm      = imm_j;
            dec.target   = target_j;
            dec.misalign = is_misaligned(target_j[1:0], IALIGN);
         end
         OP_JALR: begin
            // Illegal encodings leave every field but link/illegal at zero.
            if (funct3 == 3'b000) begin
               dec.ctrl = JALR;
               dec.rd   = instr[11:7];
               dec.rs1  = instr[19:15];
               dec.imm  = imm_i;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OP_BRANCH: begin
            if (EN_BRANCH) begin
               if (funct3 == F3_RSVD_A || funct3 == F3_RSVD_B) begin
                  dec.illegal = 1'b1;
               end else begin
                  dec.ctrl     = BRANCH;
                  dec.funct3   = funct3;
                  dec.rs1      = instr[19:15];
                  dec.rs2      = instr[24:20];
                  dec.imm      = imm_b;
                  dec.target   = target_b;
                  dec.misalign = is_misaligned(target_b[1:0], IALIGN);
               end
            end
         end
         default: ;
      endcase
   end

   pipe_skid_buffer #(
      .T (jdec_t)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (bus.flush),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (dec),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (head)
   );

   assign bus.out_ctrl     = head.ctrl;
   assign bus.out_funct3   = head.funct3;
   assign bus.out_rd       = head.rd;
   assign bus.out_rs1      = head.rs1;
   assign bus.out_rs2      = head.rs2;
   assign bus.out_imm      = head.imm;
   assign bus.out_target   = head.target;
   assign bus.out_link     = head.link;
   assign bus.out_illegal  = head.illegal;
   assign bus.out_misalign = head.misalign;

endmodule

// File: tb/tb_jump_branch_decode_pipe.sv
// tb/tb_jump_branch_decode_pipe.sv - self-checking bench for jump_branch_decode_pipe
module tb_jump_branch_decode_pipe;
   import jump_decode_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   jump_branch_decode_pipe_if #(.XLEN(32)) bus ();

   jump_branch_decode_pipe #(
      .XLEN      (32),
      .IALIGN    (32),
      .EN_BRANCH (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int    n_cmp = 0;
   int    n_err = 0;
   int    n_acc = 0;
   jdec_t sb_q[$];

   // Reference decode written from the instruction-format bit layout with
   // shift/mask arithmetic.
   function automatic jdec_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
      jdec_t       r;
      logic [31:0] ii, ib, ij;
      logic [2:0]  f3;
      f3 = instr[14:12];
      ii = 32'($signed(instr) >>> 20);
      ib = (32'($signed(instr) >>> 19) & 32'hFFFF_F000) | ((instr >> 20) & 32'h7E0)
         | ((instr >> 7) & 32'h1E) | ((instr << 4) & 32'h800);
      ij = (32'($signed(instr) >>> 11) & 32'hFFF0_0000) | (instr & 32'h000F_F000)
         | ((instr >> 9) & 32'h800) | ((instr >> 20) & 32'h7FE);
      r = '0;
      r.link = pc + 32'd4;
      case (instr[6:0])
         7'b1101111: begin
            r.ctrl = JAL; r.rd = instr[11:7]; r.imm = ij; r.target = pc + ij;
            r.misalign = (r.target % 4) != 0;
         end
         7'b1100111: begin
            if (f3 == 3'd0) begin
               r.ctrl = JALR; r.rd = instr[11:7]; r.rs1 = instr[19:15]; r.imm = ii;
            end else r.illegal = 1'b1;
         end
         7'b1100011: begin
            if (f3 == 3'd2 || f3 == 3'd3) r.illegal = 1'b1;
            else begin
               r.ctrl = BRANCH; r.funct3 = f3; r.rs1 = instr[19:15]; r.rs2 = instr[24:20];
               r.imm = ib; r.target = pc + ib; r.misalign = (r.target % 4) != 0;
            end
         end
         default: ;
      endcase
      return r;
   endfunction

   // Scoreboard: every beat popped downstream must match the oldest accepted entry.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         jdec_t got, expv;
         got.ctrl = bus.out_ctrl;     got.funct3 = bus.out_funct3;
         got.rd = bus.out_rd;         got.rs1 = bus.out_rs1;       got.rs2 = bus.out_rs2;
         got.imm = bus.out_imm;       got.target = bus.out_target; got.link = bus.out_link;
         got.illegal = bus.out_illegal; got.misalign = bus.out_misalign;
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got %h, required no output", got);
         end else begin
            expv = sb_q.pop_front();
            if (got !== expv) begin
               n_err++;
               $display("FAIL sb_entry: got %h, required %h", got, expv);
            end
         end
      end
   end

   task automatic send(input logic [31:0] instr, input logic [31:0] pc);
      bit acc = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      bus.in_pc    = pc;
      for (int i = 0; i < 64 && !acc; i++) begin
         @(negedge clk);
         acc = bus.in_ready && !bus.flush;
         @(posedge clk);
      end
      n_cmp++;
      if (acc) begin
         sb_q.push_back(ref_decode(instr, pc));
         n_acc++;
      end else begin
         n_err++;
         $display("FAIL send_accept: got no accept in 64 cycles, required accept of %h", instr);
      end
      #1;
   endtask

   task automatic drain(output bit ok);
      for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
      #1;
      ok = (sb_q.size() == 0);
   endtask

   task automatic test_reset;
      bus.flush = 0; bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0; bus.out_ready = 0;
      rst_n = 1'b0;
      #12;
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, bus.out_ctrl, bus.out_link, bus.out_target, bus.out_illegal} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got valid=%b ready=%b ctrl=%0d link=%h target=%h, required all 0",
                  bus.out_valid, bus.in_ready, bus.out_ctrl, bus.out_link, bus.out_target);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
         n_err++; $display("FAIL reset_ready_before_edge: got %b, required 0", bus.in_ready);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_ready_after_edge: got %b, required 1", bus.in_ready);
      end
   endtask

   task automatic test_jal;
      bit ok;
      bus.out_ready = 1'b1;
      send(32'h008000EF, 32'h100);
      bus.in_valid = 1'b0;
      n_cmp++;
      if ({bus.out_valid, bus.out_ctrl, bus.out_rd, bus.out_imm, bus.out_target, bus.out_link, bus.out_misalign}
          !== {1'b1, JAL, 5'd1, 32'd8, 32'h108, 32'h104, 1'b0}) begin
         n_err++;
         $display("FAIL jal_fields: got v=%b ctrl=%0d rd=%0d imm=%h tgt=%h link=%h, required v=1 ctrl=1 rd=1 imm=8 tgt=108 link=104",
                  bus.out_valid, bus.out_ctrl, bus.out_rd, bus.out_imm, bus.out_target, bus.out_link);
      end
      send(32'h008000EF, 32'hFFFF_FFFC);
      bus.in_valid = 1'b0;
      n_cmp++;
      if ({bus.out_link, bus.out_target} !== {32'h0, 32'h4}) begin
         n_err++;
         $display("FAIL jal_wrap: got link=%h tgt=%h, required link=0 tgt=4", bus.out_link, bus.out_target);
      end
      drain(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL jal_drain: got %0d left, required 0", sb_q.size()); end
   endtask

   task automatic test_jalr;
      bit ok;
      bus.out_ready = 1'b1;
      send(32'h00008067, 32'h300);
      bus.in_valid = 1'b0;
      n_cmp++;
      if ({bus.out_ctrl, bus.out_rd, bus.out_rs1, bus.out_imm, bus.out_target, bus.out_illegal}
          !== {JALR, 5'd0, 5'd1, 32'd0, 32'd0, 1'b0}) begin
         n_err++;
         $display("FAIL jalr_fields: got ctrl=%0d rs1=%0d imm=%h tgt=%h ill=%b, required ctrl=2 rs1=1 imm=0 tgt=0 ill=0",
                  bus.out_ctrl, bus.out_rs1, bus.out_imm, bus.out_target, bus.out_illegal);
      end
      send(32'h00009067, 32'h300);
      bus.in_valid = 1'b0;
      n_cmp++;
      if ({bus.out_ctrl, bus.out_illegal, bus.out_link} !== {JMP_NOP, 1'b1, 32'h304}) begin
         n_err++;
         $display("FAIL jalr_illegal: got ctrl=%0d ill=%b link=%h, required ctrl=0 ill=1 link=304",
                  bus.out_ctrl, bus.out_illegal, bus.out_link);
      end
      drain(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL jalr_drain: got %0d left, required 0", sb_q.size()); end
   endtask

   task automatic test_branch;
      bit ok;
      bus.out_ready = 1'b1;
      send(32'hFE208EE3, 32'h200);
      bus.in_valid = 1'b0;
      n_cmp++;
      if ({bus.out_ctrl, bus.out_funct3, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_target}
          !== {BRANCH, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'h1FC}) begin
         n_err++;
         $display("FAIL beq_fields: got ctrl=%0d f3=%0d rs1=%0d rs2=%0d imm=%h tgt=%h, required ctrl=3 f3=0 rs1=1 rs2=2 imm=fffffffc tgt=1fc",
                  bus.out_ctrl, bus.out_funct3, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_target);
      end
      send(32'h00002063, 32'h200);
      bus.in_valid = 1'b0;
      n_cmp++;
      if ({bus.out_ctrl, bus.out_illegal, bus.out_funct3} !== {JMP_NOP, 1'b1, 3'd0}) begin
         n_err++;
         $display("FAIL branch_illegal: got ctrl=%0d ill=%b f3=%0d, required ctrl=0 ill=1 f3=0",
                  bus.out_ctrl, bus.out_illegal, bus.out_funct3);
      end
      send(32'h00000013, 32'h400);
      bus.in_valid = 1'b0;
      n_cmp++;
      if ({bus.out_valid, bus.out_ctrl, bus.out_illegal, bus.out_imm, bus.out_link}
          !== {1'b1, JMP_NOP, 1'b0, 32'd0, 32'h404}) begin
         n_err++;
         $display("FAIL non_control: got v=%b ctrl=%0d imm=%h link=%h, required v=1 ctrl=0 imm=0 link=404",
                  bus.out_valid, bus.out_ctrl, bus.out_imm, bus.out_link);
      end
      drain(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL branch_drain: got %0d left, required 0", sb_q.size()); end
   endtask

   task automatic test_backpressure;
      bit ok;
      int base;
      base = n_acc;
      bus.out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) send(32'h0000_006F | (32'(i + 1) << 21), 32'h1000 + 32'(i * 4));
            bus.in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            n_cmp++;
            if ({32'(n_acc - base), bus.in_ready, bus.out_valid} !== {32'd2, 1'b0, 1'b1}) begin
               n_err++;
               $display("FAIL bp_stall: got acc=%0d in_ready=%b out_valid=%b, required acc=2 in_ready=0 out_valid=1",
                        n_acc - base, bus.in_ready, bus.out_valid);
            end
            bus.out_ready = 1'b1;
         end
      join
      drain(ok);
      n_cmp++;
      if (!ok || (n_acc - base) != 4) begin
         n_err++;
         $display("FAIL bp_drain: got acc=%0d left=%0d, required acc=4 left=0", n_acc - base, sb_q.size());
      end
   endtask

   task automatic test_flush;
      bus.out_ready = 1'b0;
      send(32'h0040006F, 32'h2000);
      send(32'h0080006F, 32'h2004);
      bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
         n_err++; $display("FAIL flush_full_ready: got %b, required 0", bus.in_ready);
      end
      bus.in_valid = 1'b1; bus.in_instr = 32'h00C0006F; bus.in_pc = 32'h2008; bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      sb_q.delete();
      n_cmp++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL flush_full: got out_valid=%b in_ready=%b, required out_valid=0 in_ready=1",
                  bus.out_valid, bus.in_ready);
      end
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_err++; $display("FAIL flush_dropped: got out_valid=%b, required 0", bus.out_valid);
      end
      // Flush from ONE while the head is being popped: head still delivered, input dropped.
      send(32'h0100006F, 32'h3000);
      bus.in_instr = 32'h0140006F; bus.in_pc = 32'h3004; bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, 32'(sb_q.size())} !== {1'b0, 1'b1, 32'd0}) begin
         n_err++;
         $display("FAIL flush_with_pop: got out_valid=%b in_ready=%b undelivered=%0d, required 0 1 0",
                  bus.out_valid, bus.in_ready, sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_misalign_reset;
      bit ok;
      bus.out_ready = 1'b1;
      send(32'h0020006F, 32'h0);
      bus.in_valid = 1'b0;
      n_cmp++;
      if ({bus.out_ctrl, bus.out_target, bus.out_misalign} !== {JAL, 32'h2, 1'b1}) begin
         n_err++;
         $display("FAIL misalign: got ctrl=%0d tgt=%h mis=%b, required ctrl=1 tgt=2 mis=1",
                  bus.out_ctrl, bus.out_target, bus.out_misalign);
      end
      drain(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL misalign_drain: got %0d left, required 0", sb_q.size()); end
      bus.out_ready = 1'b0;
      send(32'h0040006F, 32'h5000);
      send(32'h0080006F, 32'h5004);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, bus.out_target, bus.out_ctrl} !== '0) begin
         n_err++;
         $display("FAIL async_reset: got out_valid=%b in_ready=%b tgt=%h ctrl=%0d, required all 0",
                  bus.out_valid, bus.in_ready, bus.out_target, bus.out_ctrl);
      end
      bus.in_valid = 1'b0;
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL reset_recover: got out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
      end
      bus.out_ready = 1'b1;
   endtask

   task automatic test_back_to_back;
      bit ok;
      bit done;
      int base;
      done = 1'b0;
      base = n_acc;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               logic [31:0] r, pc;
               logic [6:0]  op;
               r  = $urandom;
               pc = $urandom;
               case ($urandom_range(0, 3))
                  0:       op = 7'b1101111;
                  1:       op = 7'b1100111;
                  2:       op = 7'b1100011;
                  default: op = r[6:0];
               endcase
               send({r[31:7], op}, pc);
            end
            bus.in_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b1;
         end
      join
      drain(ok);
      n_cmp++;
      if (!ok || (n_acc - base) != 40) begin
         n_err++;
         $display("FAIL b2b_drain: got acc=%0d left=%0d, required acc=40 left=0", n_acc - base, sb_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by %0t, required finish", $time);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_jal();
      test_jalr();
      test_branch();
      test_backpressure();
      test_flush();
      test_misalign_reset();
      test_back_to_back();
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
